// File: rtl/ecc_apb_driver.sv
// APB initiator that programs the ECC encoder/decoder register file with four
// zero-wait writes, waits for operation_done (bounded) and returns one result.
module ecc_apb_driver #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 op_ctrl,
    input  logic [AMBA_WORD-1:0]       op_data,
    input  logic [1:0]                 op_width,
    input  logic [AMBA_WORD-1:0]       op_noise,
    output logic                       busy,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       result_valid,
    output logic [DATA_WIDTH-1:0]      result_data,
    output logic [1:0]                 result_errors,
    output logic                       timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic [1:0]                   idx_q, idx_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [1:0]                   ctrl_q, ctrl_d;
    logic [AMBA_WORD-1:0]         data_q, data_d;
    logic [1:0]                   width_q, width_d;
    logic [AMBA_WORD-1:0]         noise_q, noise_d;
    logic                         busy_q, busy_d;
    logic [AMBA_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [AMBA_WORD-1:0]         pwdata_q, pwdata_d;
    logic                         psel_q, psel_d;
    logic                         penable_q, penable_d;
    logic                         rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
    logic [1:0]                   rerr_q, rerr_d;
    logic                         tout_q, tout_d;

    logic [1:0]                   nxt_idx_s;
    logic [AMBA_ADDR_WIDTH-1:0]   nxt_addr_s;
    logic [AMBA_WORD-1:0]         nxt_wdata_s;

    // Register sequence DATA_IN, CODEWORD_WIDTH, NOISE, CTRL: CTRL goes last because it launches the op
    always_comb begin
        nxt_idx_s = idx_q + 2'd1;
        case (nxt_idx_s)
            2'd0: begin
                nxt_addr_s  = AMBA_ADDR_WIDTH'(8'h04);
                nxt_wdata_s = data_q;
            end
            2'd1: begin
                nxt_addr_s  = AMBA_ADDR_WIDTH'(8'h08);
                nxt_wdata_s = AMBA_WORD'(width_q);
            end
            2'd2: begin
                nxt_addr_s  = AMBA_ADDR_WIDTH'(8'h0C);
                nxt_wdata_s = noise_q;
            end
            default: begin
                nxt_addr_s  = AMBA_ADDR_WIDTH'(8'h00);
                nxt_wdata_s = AMBA_WORD'(ctrl_q);
            end
        endcase
    end

    // Next-state and next-output logic; every output is registered
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        data_d    = data_q;
        width_d   = width_q;
        noise_d   = noise_q;
        busy_d    = busy_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        tout_d    = tout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SETUP;
                    ctrl_d    = op_ctrl;
                    data_d    = op_data;
                    width_d   = op_width;
                    noise_d   = op_noise;
                    idx_d     = 2'd0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = AMBA_ADDR_WIDTH'(8'h04);
                    pwdata_d  = op_data;
                    rdata_d   = '0;
                    rerr_d    = 2'b00;
                    tout_d    = 1'b0;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                penable_d = 1'b0;
                if (idx_q == 2'd3) begin
                    state_d = ST_WAIT;
                    psel_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d  = ST_SETUP;
                    idx_d    = nxt_idx_s;
                    paddr_d  = nxt_addr_s;
                    pwdata_d = nxt_wdata_s;
                end
            end
            ST_WAIT: begin
                // done takes priority over the limit landing in the same cycle
                if (operation_done) begin
                    state_d  = ST_RESULT;
                    rvalid_d = 1'b1;
                    rdata_d  = data_out;
                    rerr_d   = num_of_errors;
                    tout_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_RESULT;
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    rerr_d   = 2'b11;
                    tout_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESULT: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            ctrl_q    <= 2'd0;
            data_q    <= '0;
            width_q   <= 2'd0;
            noise_q   <= '0;
            busy_q    <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 2'b00;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            data_q    <= data_d;
            width_q   <= width_d;
            noise_q   <= noise_d;
            busy_q    <= busy_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
            tout_q    <= tout_d;
        end
    end

    assign busy          = busy_q;
    assign PADDR         = paddr_q;
    assign PWDATA        = pwdata_q;
    assign PSEL          = psel_q;
    assign PENABLE       = penable_q;
    assign PWRITE        = psel_q;
    assign result_valid  = rvalid_q;
    assign result_data   = rdata_q;
    assign result_errors = rerr_q;
    assign timeout       = tout_q;

endmodule

// File: tb/tb_ecc_apb_driver.sv
// Scoreboard bench for ecc_apb_driver: expected APB writes and results are
// queued when an operation is started and popped as the DUT produces them.
module tb_ecc_apb_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op_ctrl = 2'd0;
    logic [31:0] op_data = 32'd0;
    logic [1:0]  op_width = 2'd0;
    logic [31:0] op_noise = 32'd0;
    logic        busy;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic        PSEL, PENABLE, PWRITE;
    logic        operation_done = 1'b0;
    logic [31:0] data_out = 32'd0;
    logic [1:0]  num_of_errors = 2'd0;
    logic        result_valid;
    logic [31:0] result_data;
    logic [1:0]  result_errors;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [19:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [31:0] d; logic [1:0] e; logic t; int c; } res_t;
    wr_t  exp_wr[$];
    res_t exp_res[$];

    ecc_apb_driver #(
        .DATA_WIDTH(32), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .op_ctrl(op_ctrl), .op_data(op_data),
        .op_width(op_width), .op_noise(op_noise), .busy(busy), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .operation_done(operation_done), .data_out(data_out),
        .num_of_errors(num_of_errors), .result_valid(result_valid),
        .result_data(result_data), .result_errors(result_errors), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full operation: writes, wait phase, result beat, first IDLE cycle.
    // poke adds start-while-busy, done-during-writes and start-in-RESULT collisions.
    task automatic do_op(input logic [1:0] ctrl, input logic [31:0] data,
                         input logic [1:0] width, input logic [31:0] noise,
                         input int done_at, input logic [31:0] dout,
                         input logic [1:0] nerr, input bit poke);
        res_t r;
        wr_t  w;
        bit   seen;
        exp_wr.push_back('{20'h00004, data});
        exp_wr.push_back('{20'h00008, {30'd0, width}});
        exp_wr.push_back('{20'h0000C, noise});
        exp_wr.push_back('{20'h00000, {30'd0, ctrl}});
        if (done_at >= 1 && done_at <= 8) r = '{dout, nerr, 1'b0, done_at + 1};
        else                              r = '{32'd0, 2'b11, 1'b1, 9};
        exp_res.push_back(r);
        start = 1'b1; op_ctrl = ctrl; op_data = data; op_width = width; op_noise = noise;
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            total++;
            if (PSEL !== 1'b1 || PWRITE !== 1'b1 || busy !== 1'b1 || PENABLE !== (k % 2 == 0)) begin
                bad++;
                $display("FAIL apb_ctrl k=%0d: got psel=%b pwrite=%b busy=%b penable=%b, want 1 1 1 %0d",
                         k, PSEL, PWRITE, busy, PENABLE, (k % 2 == 0));
            end
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL apb_queue k=%0d: scoreboard empty", k);
            end else begin
                w = exp_wr[0];
                if (k % 2 == 0) void'(exp_wr.pop_front());
                if (PADDR !== w.a || PWDATA !== w.d) begin
                    bad++;
                    $display("FAIL apb_write k=%0d: got (%h,%h) want (%h,%h)", k, PADDR, PWDATA, w.a, w.d);
                end
            end
            if (poke && k == 3) begin
                start = 1'b1; op_data = ~data; op_ctrl = ~ctrl;
            end else if (poke && k == 4) begin
                start = 1'b0; operation_done = 1'b1; data_out = 32'hDEAD_BEEF; num_of_errors = 2'd2;
            end else begin
                start = 1'b0; operation_done = 1'b0;
            end
            step();
        end
        total++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PADDR !== 20'h0 || PWDATA !== {30'd0, ctrl}) begin
            bad++;
            $display("FAIL apb_idle_hold: got psel=%b pen=%b (%h,%h) want 0 0 (00000,%h)",
                     PSEL, PENABLE, PADDR, PWDATA, {30'd0, ctrl});
        end
        seen = 1'b0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            if (result_valid === 1'b1) begin
                seen = 1'b1;
                r = exp_res.pop_front();
                total++;
                if (result_data !== r.d || result_errors !== r.e || timeout !== r.t || c != r.c || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL result: got data=%h err=%b to=%b cyc=%0d busy=%b want %h %b %b %0d 1",
                             result_data, result_errors, timeout, c, busy, r.d, r.e, r.t, r.c);
                end
                start = poke;
                operation_done = 1'b0;
            end else begin
                operation_done = (c == done_at);
                data_out = (c == done_at) ? dout : $urandom;
                num_of_errors = (c == done_at) ? nerr : 2'd2;
            end
            step();
        end
        start = 1'b0;
        operation_done = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL result_timeout: no result_valid within 30 cycles, want one");
            void'(exp_res.pop_front());
        end
        total++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || PSEL !== 1'b0 ||
            result_data !== r.d || result_errors !== r.e || timeout !== r.t) begin
            bad++;
            $display("FAIL result_hold: got valid=%b busy=%b psel=%b data=%h err=%b to=%b want 0 0 0 %h %b %b",
                     result_valid, busy, PSEL, result_data, result_errors, timeout, r.d, r.e, r.t);
        end
    endtask

    task automatic test_reset();
        step();
        total++;
        if (busy !== 1'b0 || PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PADDR !== 20'h0 ||
            PWDATA !== 32'h0 || result_valid !== 1'b0 || result_data !== 32'h0 || result_errors !== 2'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b psel=%b pen=%b pw=%b a=%h d=%h rv=%b rd=%h re=%b to=%b want all 0",
                     busy, PSEL, PENABLE, PWRITE, PADDR, PWDATA, result_valid, result_data, result_errors, timeout);
        end
        rst = 1'b1;
        step();
        start = 1'b1; op_ctrl = 2'd2; op_data = 32'h1234; op_width = 2'd1; op_noise = 32'h3;
        step();
        start = 1'b0;
        step();
        total++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_access: got psel=%b pen=%b want 1 1", PSEL, PENABLE);
        end
        rst = 1'b0;
        #1;
        total++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got psel=%b pen=%b busy=%b want 0 0 0", PSEL, PENABLE, busy);
        end
        step();
        rst = 1'b1;
        for (int c = 0; c < 16; c++) begin
            operation_done = (c == 8);
            data_out = 32'hFFFF_0000;
            step();
            total++;
            if (result_valid !== 1'b0 || busy !== 1'b0 || PSEL !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_result c=%0d: got rv=%b busy=%b psel=%b want 0 0 0", c, result_valid, busy, PSEL);
            end
        end
        operation_done = 1'b0;
    endtask

    task automatic test_encode();
        do_op(2'd0, 32'h0000_005A, 2'd0, 32'h0, 2, 32'h0000_1234, 2'd0, 1'b0);
    endtask

    task automatic test_decode();
        do_op(2'd1, 32'h0BAD_F00D, 2'd2, 32'h0000_0100, 3, 32'h0000_00A5, 2'd1, 1'b0);
    endtask

    task automatic test_timeout();
        do_op(2'd2, 32'hCAFE_0001, 2'd1, 32'h8000_0001, 0, 32'h0, 2'd0, 1'b0);
    endtask

    task automatic test_collisions();
        do_op(2'd1, 32'h1357_9BDF, 2'd3, 32'h0000_0011, 8, 32'h0000_7777, 2'd3, 1'b1);
        step();
        total++;
        if (busy !== 1'b0 || PSEL !== 1'b0) begin
            bad++;
            $display("FAIL start_in_result: got busy=%b psel=%b want 0 0", busy, PSEL);
        end
    endtask

    task automatic test_back_to_back();
        do_op(2'd0, 32'h0000_00C3, 2'd1, 32'h0000_0002, 5, 32'h0000_0042, 2'd0, 1'b0);
        do_op(2'd2, 32'h7FFF_FFFF, 2'd2, 32'h0000_0400, 1, 32'hFFFF_FFFE, 2'd2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_encode();
        test_decode();
        test_timeout();
        test_collisions();
        test_back_to_back();
        total++;
        if (exp_wr.size() != 0 || exp_res.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d writes %0d results left, want 0 0", exp_wr.size(), exp_res.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
